// File: rtl/smi_pkg.sv
// Shared SMI definitions: end-of-frame control width/encoding and arbiter state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package smi_pkg;

  localparam int SMI_EOFC_WIDTH = 8;
  localparam logic [SMI_EOFC_WIDTH-1:0] SMI_EOFC_NONE = 8'd0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  // One-hot owner encoding presented on grantOwner.
  function automatic logic [1:0] owner_onehot(arb_state_t s);
    case (s)
      ARB_OWN0: owner_onehot = 2'b01;
      ARB_OWN1: owner_onehot = 2'b10;
      default:  owner_onehot = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/smi_frame_arbiter_x2_if.sv
// One SMI flit link: ready (valid), eofc, data forward; stop backward.
// Latency: n/a (wires only).
// Backpressure: a flit moves when ready=1 and stop=0 in the same cycle.
interface smi_frame_arbiter_x2_if #(
  parameter int FlitWidth = 8
) ();
  import smi_pkg::*;

  logic                      ready;
  logic [SMI_EOFC_WIDTH-1:0] eofc;
  logic [FlitWidth*8-1:0]    data;
  logic                      stop;

  // master sources flits, slave sinks them and drives stop.
  modport master (output ready, output eofc, output data, input stop);
  modport slave  (input ready, input eofc, input data, output stop);
endinterface

// File: rtl/smi_arb_skid_buffer.sv
// Two-entry flit FIFO with registered storage between arbiter mux and SMI output.
// Latency: a flit pushed in cycle N is at the head in cycle N+1.
// Backpressure: in_stop while both entries are full; head held while out_stop=1.
// Ports: clk/rst (async active-high), in_ready/in_data/in_stop (write side),
//        out_ready/out_data/out_stop (read side).
module smi_arb_skid_buffer #(
  parameter int Width = 72
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             in_stop,
  output logic             out_ready,
  output logic [Width-1:0] out_data,
  input  logic             out_stop
);

  logic [Width-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // Full stalls the writer even if a pop happens this cycle; keeps stop
  // a pure function of registered state.
  assign in_stop   = (count == 2'd2);
  assign out_ready = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_ready && !in_stop;
  assign pop       = out_ready && !out_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/smi_frame_arbiter_x2.sv
// Frame-atomic round-robin merge of two SMI flit streams onto one SMI output.
// Latency: one arbitration cycle from IDLE, then flit accepted in N appears in N+1.
// Backpressure: only the owner may be unstopped, and only while the buffer has room.
// Ports: clk, srst (async active-high), smiIn0/smiIn1 (slave links),
//        smiOut (master link), grantOwner (one-hot owner, 00 = idle).
module smi_frame_arbiter_x2
  import smi_pkg::*;
#(
  parameter int FlitWidth = 8
) (
  input  logic                   clk,
  input  logic                   srst,
  smi_frame_arbiter_x2_if.slave  smiIn0,
  smi_frame_arbiter_x2_if.slave  smiIn1,
  smi_frame_arbiter_x2_if.master smiOut,
  output logic [1:0]             grantOwner
);

  localparam int DataWidth = FlitWidth * 8;
  localparam int BufWidth  = DataWidth + SMI_EOFC_WIDTH;

  arb_state_t          state;
  arb_state_t          state_nxt;
  logic                last_grant;      // index of the input that finished the last frame
  logic                last_grant_nxt;
  logic                stop0;
  logic                stop1;
  logic                push_ready;
  logic [BufWidth-1:0] push_flit;
  logic                buf_full;
  logic [BufWidth-1:0] buf_out;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;  // so input 0 wins the first contested arbitration
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    stop0          = 1'b1;
    stop1          = 1'b1;
    push_ready     = 1'b0;
    push_flit      = {smiIn0.eofc, smiIn0.data};
    case (state)
      ARB_IDLE: begin
        // Arbitration cycle: nothing transfers, owner chosen for next cycle.
        if (smiIn0.ready && smiIn1.ready) begin
          state_nxt = last_grant ? ARB_OWN0 : ARB_OWN1;
        end else if (smiIn0.ready) begin
          state_nxt = ARB_OWN0;
        end else if (smiIn1.ready) begin
          state_nxt = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        stop0      = buf_full;
        push_ready = smiIn0.ready;
        push_flit  = {smiIn0.eofc, smiIn0.data};
        // Frame ends on an accepted eofc flit; hand straight to the other
        // input if it is waiting, so back-to-back frames cost no idle cycle.
        if (smiIn0.ready && !buf_full && (smiIn0.eofc != SMI_EOFC_NONE)) begin
          last_grant_nxt = 1'b0;
          state_nxt      = smiIn1.ready ? ARB_OWN1 : ARB_IDLE;
        end
      end
      ARB_OWN1: begin
        stop1      = buf_full;
        push_ready = smiIn1.ready;
        push_flit  = {smiIn1.eofc, smiIn1.data};
        if (smiIn1.ready && !buf_full && (smiIn1.eofc != SMI_EOFC_NONE)) begin
          last_grant_nxt = 1'b1;
          state_nxt      = smiIn0.ready ? ARB_OWN0 : ARB_IDLE;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign smiIn0.stop = stop0;
  assign smiIn1.stop = stop1;
  assign grantOwner  = owner_onehot(state);

  smi_arb_skid_buffer #(
    .Width(BufWidth)
  ) u_buf (
    .clk       (clk),
    .rst       (srst),
    .in_ready  (push_ready),
    .in_data   (push_flit),
    .in_stop   (buf_full),
    .out_ready (smiOut.ready),
    .out_data  (buf_out),
    .out_stop  (smiOut.stop)
  );

  assign smiOut.eofc = buf_out[BufWidth-1 -: SMI_EOFC_WIDTH];
  assign smiOut.data = buf_out[DataWidth-1:0];

endmodule

// File: tb/tb_smi_frame_arbiter_x2.sv
// Bench for smi_frame_arbiter_x2: directed scenarios plus randomized traffic
// checked against per-input frame queues (frames intact, in order, never interleaved).
module tb_smi_frame_arbiter_x2;

  localparam int FW = 8;
  localparam int DW = FW * 8;

  typedef struct packed {
    logic [7:0]    eofc;
    logic [DW-1:0] data;
  } flit_t;

  logic       clk;
  logic       srst;
  logic [1:0] grantOwner;

  smi_frame_arbiter_x2_if #(.FlitWidth(FW)) in0_if ();
  smi_frame_arbiter_x2_if #(.FlitWidth(FW)) in1_if ();
  smi_frame_arbiter_x2_if #(.FlitWidth(FW)) out_if ();

  smi_frame_arbiter_x2 #(.FlitWidth(FW)) dut (
    .clk        (clk),
    .srst       (srst),
    .smiIn0     (in0_if),
    .smiIn1     (in1_if),
    .smiOut     (out_if),
    .grantOwner (grantOwner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Traffic source queues and expected-in-flight queues per input.
  flit_t sendq0[$];
  flit_t sendq1[$];
  flit_t expq0[$];
  flit_t expq1[$];

  // Per-cycle observations of the last run.
  logic [1:0] gnt_log[$];
  bit         outv_log[$];
  bit         stop0_log[$];
  int         frame_src_log[$];
  int         out_count;
  int         eof_acc0;
  bit         out_mid;
  int         out_src;

  // Run knobs.
  int p_rdy0, p_rdy1, p_stop;
  int stop_from, stop_to;
  int drop0_from, drop0_to;

  task automatic do_reset();
    in0_if.ready = 1'b0; in0_if.eofc = '0; in0_if.data = '0;
    in1_if.ready = 1'b0; in1_if.eofc = '0; in1_if.data = '0;
    out_if.stop  = 1'b0;
    srst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    sendq0.delete(); sendq1.delete(); expq0.delete(); expq1.delete();
    stop_from = 0; stop_to = 0; drop0_from = 0; drop0_to = 0;
    p_rdy0 = 100; p_rdy1 = 100; p_stop = 0;
  endtask

  // Data layout: [63:56]=source, [55:40]=frame id, [39:32]=flit index, rest random.
  task automatic make_frame(input int src, input int len, input int fid, input logic [7:0] last_eofc);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      f.data = {8'(src), 16'(fid), 8'(i), 32'($urandom)};
      if (i == len - 1) f.eofc = (last_eofc != 8'd0) ? last_eofc : 8'($urandom_range(1, 255));
      else              f.eofc = 8'd0;
      if (src == 0) sendq0.push_back(f);
      else          sendq1.push_back(f);
    end
  endtask

  // Cycle-driven source/sink with inline scoreboard on every output flit.
  task automatic run_traffic(input int max_cycles);
    bit held0, held1, acc0, acc1, outx, in_drop;
    flit_t got, exp;
    int src;
    held0 = 0; held1 = 0;
    gnt_log.delete(); outv_log.delete(); stop0_log.delete(); frame_src_log.delete();
    out_count = 0; eof_acc0 = -1; out_mid = 0; out_src = -1;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      in_drop = (c >= drop0_from) && (c < drop0_to);
      if (held0 || (sendq0.size() > 0 && !in_drop && $urandom_range(0, 99) < p_rdy0)) begin
        in0_if.ready = 1'b1; {in0_if.eofc, in0_if.data} = sendq0[0];
      end else begin
        in0_if.ready = 1'b0; in0_if.eofc = 8'($urandom); in0_if.data = {$urandom, $urandom};
      end
      if (held1 || (sendq1.size() > 0 && $urandom_range(0, 99) < p_rdy1)) begin
        in1_if.ready = 1'b1; {in1_if.eofc, in1_if.data} = sendq1[0];
      end else begin
        in1_if.ready = 1'b0; in1_if.eofc = 8'($urandom); in1_if.data = {$urandom, $urandom};
      end
      out_if.stop = ((c >= stop_from) && (c < stop_to)) || ($urandom_range(0, 99) < p_stop);
      #1;
      gnt_log.push_back(grantOwner);
      outv_log.push_back(out_if.ready);
      stop0_log.push_back(in0_if.stop);
      acc0 = in0_if.ready && !in0_if.stop;
      acc1 = in1_if.ready && !in1_if.stop;
      outx = out_if.ready && !out_if.stop;
      checks++;
      if (acc0 && acc1) begin
        errors++;
        $display("FAIL dual_accept cycle %0d: both inputs unstopped while ready, required at most one", c);
      end
      if (outx) begin
        got = {out_if.eofc, out_if.data};
        src = int'(out_if.data[DW-1 -: 8]);
        out_count++;
        checks++;
        if (src == 0 && expq0.size() > 0)      exp = expq0.pop_front();
        else if (src == 1 && expq1.size() > 0) exp = expq1.pop_front();
        else begin
          exp = '0;
          errors++;
          $display("FAIL out_unexpected cycle %0d: got %h, required no flit from source %0d", c, got, src);
        end
        if (exp != '0 && got !== exp) begin
          errors++;
          $display("FAIL out_flit cycle %0d: got %h, required %h", c, got, exp);
        end
        checks++;
        if (out_mid && src != out_src) begin
          errors++;
          $display("FAIL interleave cycle %0d: got source %0d mid-frame, required source %0d", c, src, out_src);
        end
        if (!out_mid) frame_src_log.push_back(src);
        out_mid = (got.eofc == 8'd0);
        out_src = src;
      end
      if (acc0) begin
        exp = sendq0.pop_front();
        if (exp.eofc != 8'd0) eof_acc0 = c;
        expq0.push_back(exp);
      end
      if (acc1) expq1.push_back(sendq1.pop_front());
      held0 = in0_if.ready && !acc0;
      held1 = in1_if.ready && !acc1;
      if (sendq0.size() == 0 && sendq1.size() == 0 && expq0.size() == 0 && expq1.size() == 0) break;
      if (c >= max_cycles) begin
        errors++;
        $display("FAIL timeout: %0d/%0d flits still pending after %0d cycles, required 0",
                 sendq0.size() + expq0.size(), sendq1.size() + expq1.size(), c);
        break;
      end
    end
    @(negedge clk);
    in0_if.ready = 1'b0; in1_if.ready = 1'b0; out_if.stop = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    srst = 1'b1;
    #1;
    checks++;
    if ({in0_if.stop, in1_if.stop, out_if.ready, out_if.eofc, grantOwner} !== {1'b1, 1'b1, 1'b0, 8'd0, 2'b00}
        || out_if.data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stop0/1=%b%b ready=%b eofc=%h data=%h grant=%b, required 11 0 00 0 00",
               in0_if.stop, in1_if.stop, out_if.ready, out_if.eofc, out_if.data, grantOwner);
    end
    @(negedge clk);
    srst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (grantOwner !== 2'b00 || out_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: grant=%b ready=%b with no input, required 00 0", grantOwner, out_if.ready);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    p_rdy1 = 0;
    make_frame(0, 3, 1, 8'd8);
    run_traffic(100);
    checks++;
    if (gnt_log.size() < 5) begin
      errors++;
      $display("FAIL single_len: got %0d cycles logged, required at least 5", gnt_log.size());
    end else begin
      checks++;
      if (gnt_log[0] !== 2'b00 || stop0_log[0] !== 1'b1) begin
        errors++;
        $display("FAIL single_arb: cycle0 grant=%b stop0=%b, required 00 1", gnt_log[0], stop0_log[0]);
      end
      checks++;
      if (gnt_log[1] !== 2'b01 || gnt_log[3] !== 2'b01) begin
        errors++;
        $display("FAIL single_grant: cycle1=%b cycle3=%b, required 01 01", gnt_log[1], gnt_log[3]);
      end
      checks++;
      if (gnt_log[4] !== 2'b00) begin
        errors++;
        $display("FAIL single_release: cycle4 grant=%b, required 00", gnt_log[4]);
      end
      checks++;
      if (outv_log[1] !== 1'b0 || outv_log[2] !== 1'b1) begin
        errors++;
        $display("FAIL single_latency: out valid cycle1=%b cycle2=%b, required 0 1", outv_log[1], outv_log[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first, last, gaps;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      make_frame(0, 2, f, 8'd0);
      make_frame(1, 2, f, 8'd0);
    end
    run_traffic(200);
    checks++;
    if (frame_src_log.size() != 8) begin
      errors++;
      $display("FAIL b2b_frames: got %0d frames, required 8", frame_src_log.size());
    end
    for (int i = 0; i < frame_src_log.size(); i++) begin
      checks++;
      if (frame_src_log[i] != (i % 2)) begin
        errors++;
        $display("FAIL b2b_order frame %0d: got source %0d, required %0d", i, frame_src_log[i], i % 2);
      end
    end
    first = -1; last = -1; gaps = 0;
    for (int i = 0; i < outv_log.size(); i++) if (outv_log[i]) begin
      if (first < 0) first = i;
      last = i;
    end
    for (int i = first; i >= 0 && i <= last; i++) if (!outv_log[i]) gaps++;
    checks++;
    if (gaps != 0 || out_count != 16) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d idle cycles and %0d flits, required 0 and 16", gaps, out_count);
    end
  endtask

  task automatic test_out_stall();
    int gaps;
    do_reset();
    p_rdy1 = 0;
    stop_from = 4; stop_to = 9;
    make_frame(0, 10, 7, 8'd0);
    run_traffic(200);
    checks++;
    if (stop0_log.size() < 9 || stop0_log[6] !== 1'b1 || stop0_log[8] !== 1'b1) begin
      errors++;
      $display("FAIL stall_stop0: stop0 during output stall not asserted (logged %0d cycles), required 1",
               stop0_log.size());
    end
    gaps = 0;
    for (int i = 9; i < outv_log.size(); i++) if (!outv_log[i]) gaps++;
    checks++;
    if (gaps != 0 || out_count != 10) begin
      errors++;
      $display("FAIL stall_resume: got %0d bubbles and %0d flits, required 0 and 10", gaps, out_count);
    end
  endtask

  task automatic test_owner_drop();
    int first10;
    do_reset();
    drop0_from = 3; drop0_to = 7;
    make_frame(0, 6, 2, 8'd0);
    make_frame(1, 2, 3, 8'd0);
    run_traffic(200);
    for (int c = 3; c < 7 && c < gnt_log.size(); c++) begin
      checks++;
      if (gnt_log[c] !== 2'b01) begin
        errors++;
        $display("FAIL drop_hold cycle %0d: grant=%b, required 01", c, gnt_log[c]);
      end
    end
    first10 = -1;
    for (int c = 0; c < gnt_log.size(); c++) if (first10 < 0 && gnt_log[c] === 2'b10) first10 = c;
    checks++;
    if (first10 <= eof_acc0 || eof_acc0 < 0) begin
      errors++;
      $display("FAIL drop_handoff: grant 10 at cycle %0d, eof of input0 at %0d, required later", first10, eof_acc0);
    end
    checks++;
    if (frame_src_log.size() != 2 || frame_src_log[0] != 0 || frame_src_log[1] != 1) begin
      errors++;
      $display("FAIL drop_order: got %0d frames, required source 0 then 1", frame_src_log.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    bit got;
    logic [DW-1:0] b_data;
    do_reset();
    // Single-flit frame from input 0 leaves input 1 favoured for the next contest.
    in0_if.ready = 1'b1; in0_if.eofc = 8'd5; in0_if.data = 64'hA0A0_0000_0000_0001;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1; if (!in0_if.stop) got = 1;
      @(negedge clk);
    end
    in0_if.ready = 1'b0;
    repeat (2) @(negedge clk);
    b_data = {$urandom, $urandom};
    in1_if.ready = 1'b1; in1_if.eofc = 8'd0; in1_if.data = b_data;
    for (int k = 0; k < 10 && got; k++) begin
      #1; if (!in1_if.stop) got = 0;
      @(negedge clk);
    end
    in1_if.ready = 1'b0;
    out_if.stop  = 1'b1;
    checks++;
    if (got || out_if.ready !== 1'b1 || out_if.data !== b_data) begin
      errors++;
      $display("FAIL rst_setup: buffered ready=%b data=%h, required 1 %h", out_if.ready, out_if.data, b_data);
    end
    #2 srst = 1'b1;
    #1;
    checks++;
    if (out_if.ready !== 1'b0 || out_if.data !== '0 || out_if.eofc !== 8'd0 || grantOwner !== 2'b00
        || in0_if.stop !== 1'b1 || in1_if.stop !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: ready=%b data=%h eofc=%h grant=%b stops=%b%b, required 0 0 00 00 11",
               out_if.ready, out_if.data, out_if.eofc, grantOwner, in0_if.stop, in1_if.stop);
    end
    @(negedge clk);
    srst = 1'b0;
    out_if.stop  = 1'b0;
    in0_if.ready = 1'b1; in0_if.eofc = 8'd3; in0_if.data = {$urandom, $urandom};
    in1_if.ready = 1'b1; in1_if.eofc = 8'd3; in1_if.data = {$urandom, $urandom};
    @(posedge clk);
    #1;
    checks++;
    if (grantOwner !== 2'b01 || out_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_grant: grant=%b out ready=%b, required 01 0", grantOwner, out_if.ready);
    end
    @(negedge clk);
    in0_if.ready = 1'b0; in1_if.ready = 1'b0;
  endtask

  task automatic test_random();
    int n0, n1;
    do_reset();
    p_rdy0 = 60; p_rdy1 = 60; p_stop = 30;
    for (int f = 0; f < 500; f++) begin
      make_frame(0, $urandom_range(1, 4), f, 8'd0);
      make_frame(1, $urandom_range(1, 4), f, 8'd0);
    end
    run_traffic(40000);
    n0 = 0; n1 = 0;
    foreach (frame_src_log[i]) if (frame_src_log[i] == 0) n0++; else n1++;
    checks++;
    if (n0 != 500 || n1 != 500) begin
      errors++;
      $display("FAIL random_frames: got %0d/%0d frames, required 500/500", n0, n1);
    end
  endtask

  initial begin
    srst = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_out_stall();
    test_owner_drop();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
